matchblock_feeder: RTL and testbench
====================================

Name: matchblock_feeder

Overview:
- Upstream end of the match-block interface: issues 142-bit parse-node records to a reconfigurable match region on `pnode_*` and collects 14-bit match results on `result_*`.
- Forwards results in order to the downstream action stage on `out_*`.
- Tracks in-flight requests with credits.
- Substitutes a miss code for every lost result when the region is frozen or stops responding (timeout), so the pipeline never deadlocks during partial reconfiguration.

Parameters:
- MAX_OUTSTANDING, 4: maximum requests issued without a returned result (1..15).
- TIMEOUT_CYCLES, 1024: cycles with outstanding>0 and no result before the drain starts.
- MISS_CODE, 14'h3FFF: result value synthesized for each dropped request.

Ports:
- clock  in  1  single clock
- reset  in  1  asynchronous, active-high reset
- in_data  in  142  parse-node record from the parser
- in_valid  in  1  in_data valid
- in_ready  out  1  record accepted when in_valid && in_ready
- pnode_data  out  142  record to match block
- pnode_valid  out  1  pnode_data valid
- pnode_ready  in  1  match block accepts when pnode_valid && pnode_ready
- result_data  in  14  match result
- result_valid  in  1  result valid; held by match block until acked
- result_ack  out  1  one-cycle pulse consuming the current result
- coe_freeze  in  1  region frozen (localfreeze && globalfreeze already combined)
- out_result  out  14  result to downstream
- out_valid  out  1  out_result valid
- out_ready  in  1  downstream accepts
- avs_status_read  in  1  Avalon-MM status read
- avs_status_address  in  2  0 = issued count, 1 = returned count, 2 = miss count, 3 = {state, outstanding}
- avs_status_readdata  out  32  registered, valid the cycle after the read

Behaviour:
- Reset values: every output 0, except in_ready=1. State=RUN, outstanding=0, all counters 0.
- Issue register (one entry):
  - in_ready = !issue_full || (pnode_valid && pnode_ready).
  - pnode_valid = issue_full && state==RUN && outstanding<MAX_OUTSTANDING.
  - pnode_data is stable while pnode_valid && !pnode_ready.
  - Once pnode_valid has been asserted, it is held until accepted, even if coe_freeze rises. A frozen region reports ready=1, so the hold always completes.
  - Each accept increments outstanding and the issued counter.
- Result path (output register):
  - result_ack = result_valid && (!out_valid || out_ready) && state==RUN.
  - On ack: out_result <= result_data, out_valid <= 1, outstanding decrements, returned counter increments.
  - On the cycle of any out_ready acceptance with no new load, out_valid clears.
  - Same-cycle issue and result: outstanding is unchanged.
- States:
  - RUN:
    - go to DRAIN if coe_freeze=1 (and no pnode handshake pending), or if timeout_cnt reaches TIMEOUT_CYCLES-1.
    - timeout_cnt counts while outstanding>0 and no ack occurs; it clears on any ack or when outstanding=0.
  - DRAIN:
    - no acks; each cycle with (!out_valid || out_ready) and outstanding>0 loads out_result=MISS_CODE, decrements outstanding and increments the miss counter.
    - when outstanding=0: go to FROZEN if coe_freeze=1, else RUN.
  - FROZEN:
    - no issue, no ack; in_ready follows the issue-register rule, so one record is buffered and then back-pressure applies.
    - go to RUN when coe_freeze=0.
    - any result_valid seen in FROZEN is ignored (stale).
- Ordering: results, including misses, leave strictly in issue order. Real results never follow misses for the same drain epoch.
- Counters: 32-bit, wrap modulo 2^32, no saturation.
- Status word at address 3: bits [1:0] = state (RUN=0, DRAIN=1, FROZEN=2), bits [7:4] = outstanding.
- Reset mid-operation: all in-flight requests are lost silently, no misses emitted.

Decomposition:
- Package `matchblock_pkg`: PNODE_W=142, RESULT_W=14, the state enum, and the default MISS_CODE.
- One sub-module, `matchblock_credit_timer`: outstanding counter plus timeout counter, with inc/dec/clear inputs and timeout/at_max outputs.
- The remaining logic stays in the top level.

Test Plan:
- Reset with in_valid=1 → in_ready=1, pnode_valid=0, out_valid=0, all status reads 0.
- Stream 8 records while the match block echoes result=index after 3 cycles, out_ready=1 → out_result 0..7 in order; status issued=8, returned=8, miss=0.
- MAX_OUTSTANDING=4, hold result_valid=0 → exactly 4 pnode accepts, then pnode_valid=0. After TIMEOUT_CYCLES: four 14'h3FFF outputs, miss=4, state back to RUN.
- 2 requests outstanding, then raise coe_freeze → 2 MISS_CODE outputs, state=FROZEN, result_valid ignored. Drop freeze → RUN, and the buffered record issues next cycle.
- out_ready=0 for 20 cycles with result_valid=1 → one result held stable in out_result, result_ack=0 after the first ack, no loss.
- Same-cycle pnode accept and result ack at outstanding=2 → outstanding stays 2 (status address 3).

Source files
------------

// File: rtl/matchblock_pkg.sv
// Shared widths, FSM state encoding and default miss code for the match-block feeder.
package matchblock_pkg;

    localparam int PNODE_W  = 142;
    localparam int RESULT_W = 14;
    localparam int OUTST_W  = 4;

    localparam logic [RESULT_W-1:0] DEFAULT_MISS_CODE = 14'h3FFF;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_FROZEN = 2'd2
    } state_e;

endpackage

// File: rtl/matchblock_credit_timer.sv
// In-flight request counter plus the no-response timeout that triggers a drain.
module matchblock_credit_timer
    import matchblock_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               inc_i,
    input  logic               dec_i,
    input  logic               clear_i,
    input  logic               run_i,
    output logic [OUTST_W-1:0] outstanding_o,
    output logic               at_max_o,
    output logic               timeout_o
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [OUTST_W-1:0] MAX_CNT  = OUTST_W'(MAX_OUTSTANDING);

    logic [OUTST_W-1:0] outst_q, outst_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               waiting;

    // Waiting for a result: something is in flight and nothing came back this cycle.
    assign waiting = run_i && (outst_q != '0) && !clear_i;

    // Simultaneous issue and return cancel out.
    always_comb begin
        outst_d = outst_q;
        if (inc_i && !dec_i) begin
            outst_d = outst_q + 1'b1;
        end else if (dec_i && !inc_i) begin
            outst_d = outst_q - 1'b1;
        end
    end

    // Timer saturates at its last value so a blocked drain entry keeps requesting it.
    always_comb begin
        tmr_d = '0;
        if (waiting) begin
            tmr_d = (tmr_q == TMR_LAST) ? tmr_q : tmr_q + 1'b1;
        end
    end

    // Credit and timer state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            outst_q <= '0;
            tmr_q   <= '0;
        end else begin
            outst_q <= outst_d;
            tmr_q   <= tmr_d;
        end
    end

    assign outstanding_o = outst_q;
    assign at_max_o      = (outst_q >= MAX_CNT);
    assign timeout_o     = waiting && (tmr_q == TMR_LAST);

endmodule

// File: rtl/matchblock_feeder.sv
// Feeds parse-node records to a reconfigurable match region and returns results in
// issue order, substituting a miss code for results lost to freeze or timeout.
module matchblock_feeder
    import matchblock_pkg::*;
#(
    parameter int                  MAX_OUTSTANDING = 4,
    parameter int                  TIMEOUT_CYCLES  = 1024,
    parameter logic [RESULT_W-1:0] MISS_CODE       = DEFAULT_MISS_CODE
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PNODE_W-1:0]  in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [PNODE_W-1:0]  pnode_data,
    output logic                pnode_valid,
    input  logic                pnode_ready,
    input  logic [RESULT_W-1:0] result_data,
    input  logic                result_valid,
    output logic                result_ack,
    input  logic                coe_freeze,
    output logic [RESULT_W-1:0] out_result,
    output logic                out_valid,
    input  logic                out_ready,
    input  logic                avs_status_read,
    input  logic [1:0]          avs_status_address,
    output logic [31:0]         avs_status_readdata
);

    state_e              state_q;
    logic                issue_full_q;
    logic [PNODE_W-1:0]  issue_data_q;
    logic                out_valid_q;
    logic [RESULT_W-1:0] out_result_q;
    logic [31:0]         issued_cnt_q, returned_cnt_q, miss_cnt_q, rdata_q;

    logic [OUTST_W-1:0]  outstanding;
    logic                at_max, timeout;
    logic                pnode_fire, in_fire, out_free, ack, miss_load, pnode_hold;

    assign pnode_valid = issue_full_q && (state_q == ST_RUN) && !at_max;
    assign pnode_fire  = pnode_valid && pnode_ready;
    // A presented record must complete its handshake before the FSM may leave RUN.
    assign pnode_hold  = pnode_valid && !pnode_ready;
    assign in_ready    = !issue_full_q || pnode_fire;
    assign in_fire     = in_valid && in_ready;
    assign out_free    = !out_valid_q || out_ready;
    assign ack         = result_valid && out_free && (state_q == ST_RUN);
    assign miss_load   = (state_q == ST_DRAIN) && out_free && (outstanding != '0);

    matchblock_credit_timer #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .TIMEOUT_CYCLES  (TIMEOUT_CYCLES)
    ) u_credit_timer (
        .clock         (clock),
        .reset         (reset),
        .inc_i         (pnode_fire),
        .dec_i         (ack || miss_load),
        .clear_i       (ack),
        .run_i         (state_q == ST_RUN),
        .outstanding_o (outstanding),
        .at_max_o      (at_max),
        .timeout_o     (timeout)
    );

    // Single-entry issue register between the parser and the match region.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            issue_full_q <= 1'b0;
            issue_data_q <= '0;
        end else if (in_fire) begin
            issue_full_q <= 1'b1;
            issue_data_q <= in_data;
        end else if (pnode_fire) begin
            issue_full_q <= 1'b0;
        end
    end

    // Mode FSM: drain lost requests as misses, then park while the region is frozen.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if ((coe_freeze || timeout) && !pnode_hold) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (outstanding == '0) state_q <= coe_freeze ? ST_FROZEN : ST_RUN;
                end
                ST_FROZEN: begin
                    if (!coe_freeze) state_q <= ST_RUN;
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    // Output register: real results in RUN, miss codes in DRAIN, cleared on take.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
        end else if (ack) begin
            out_valid_q  <= 1'b1;
            out_result_q <= result_data;
        end else if (miss_load) begin
            out_valid_q  <= 1'b1;
            out_result_q <= MISS_CODE;
        end else if (out_ready) begin
            out_valid_q  <= 1'b0;
        end
    end

    // Free-running statistics, wrapping modulo 2^32.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            issued_cnt_q   <= '0;
            returned_cnt_q <= '0;
            miss_cnt_q     <= '0;
        end else begin
            if (pnode_fire) issued_cnt_q   <= issued_cnt_q + 32'd1;
            if (ack)        returned_cnt_q <= returned_cnt_q + 32'd1;
            if (miss_load)  miss_cnt_q     <= miss_cnt_q + 32'd1;
        end
    end

    // Status read data, registered one cycle after the read strobe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (avs_status_read) begin
            case (avs_status_address)
                2'd0:    rdata_q <= issued_cnt_q;
                2'd1:    rdata_q <= returned_cnt_q;
                2'd2:    rdata_q <= miss_cnt_q;
                default: rdata_q <= {24'd0, outstanding, 2'b00, state_q};
            endcase
        end
    end

    assign pnode_data          = issue_data_q;
    assign result_ack          = ack;
    assign out_result          = out_result_q;
    assign out_valid           = out_valid_q;
    assign avs_status_readdata = rdata_q;

endmodule

// File: tb/tb_matchblock_feeder.sv
// Randomized and directed checks of matchblock_feeder against a request-level model:
// every issued request resolves to its region result or, if the region lost it, a miss.
module tb_matchblock_feeder;
    import matchblock_pkg::*;

    localparam int          MAXO = 4;
    localparam int          TMO  = 64;
    localparam logic [13:0] MISS = 14'h3FFF;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [141:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [141:0] pnode_data;
    logic         pnode_valid;
    logic         pnode_ready = 1'b0;
    logic [13:0]  result_data = '0;
    logic         result_valid = 1'b0;
    logic         result_ack;
    logic         coe_freeze = 1'b0;
    logic [13:0]  out_result;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         avs_status_read = 1'b0;
    logic [1:0]   avs_status_address = '0;
    logic [31:0]  avs_status_readdata;

    matchblock_feeder #(
        .MAX_OUTSTANDING (MAXO),
        .TIMEOUT_CYCLES  (TMO),
        .MISS_CODE       (MISS)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .in_data             (in_data),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .pnode_data          (pnode_data),
        .pnode_valid         (pnode_valid),
        .pnode_ready         (pnode_ready),
        .result_data         (result_data),
        .result_valid        (result_valid),
        .result_ack          (result_ack),
        .coe_freeze          (coe_freeze),
        .out_result          (out_result),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .avs_status_read     (avs_status_read),
        .avs_status_address  (avs_status_address),
        .avs_status_readdata (avs_status_readdata)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Environment policy knobs.
    int   iv_rate = 100, pr_rate = 100, or_rate = 100, lat_min = 1, lat_max = 1;
    bit   freeze_req = 0, dead = 0, hold = 0, stale = 0, rd_en = 0;
    logic [1:0] rd_addr = '0;

    // Request-level model: fate 0 = unresolved, 1 = region returned it, 2 = region lost it.
    logic [141:0] feed_q[$];
    logic [141:0] sent_q[$];
    logic [141:0] iss_q[$];
    int           fate_q[$];
    int           reg_k[$];
    int           reg_t[$];
    logic [13:0]  out_log[$];
    int           n_issued, n_ret, n_miss, n_out, cyc, acks_seen, serial;
    bit           both_fire, in_present;
    logic [31:0]  last_rd;

    function automatic logic [13:0] f_res(input logic [141:0] r);
        return r[13:0];
    endfunction

    function automatic logic [141:0] mk_rec(input int s);
        logic [12:0] low;
        low = 13'(s);
        return {$urandom(), $urandom(), $urandom(), $urandom(), 1'b0, low};
    endfunction

    task automatic chk(input string name, input logic [141:0] act, input logic [141:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        int  lat;
        bit  from_region, pf;
        logic [13:0] exp;
        @(negedge clock);
        cyc++;
        coe_freeze = freeze_req;
        if (freeze_req || dead) begin
            while (reg_k.size() > 0) begin
                fate_q[reg_k[0]] = 2;
                void'(reg_k.pop_front());
                void'(reg_t.pop_front());
            end
        end
        if (!in_present && feed_q.size() > 0 && $urandom_range(99) < iv_rate) in_present = 1;
        in_valid    = in_present;
        in_data     = in_present ? feed_q[0] : '0;
        pnode_ready = (freeze_req || dead) ? 1'b1 : ($urandom_range(99) < pr_rate);
        out_ready   = ($urandom_range(99) < or_rate);
        from_region = 0;
        if (!freeze_req && !dead && !hold && reg_k.size() > 0 && cyc >= reg_t[0]) begin
            from_region  = 1;
            result_valid = 1'b1;
            result_data  = f_res(iss_q[reg_k[0]]);
        end else if (stale) begin
            result_valid = 1'b1;
            result_data  = 14'($urandom());
        end else begin
            result_valid = 1'b0;
            result_data  = '0;
        end
        avs_status_read    = rd_en;
        avs_status_address = rd_addr;
        #1;
        last_rd   = avs_status_readdata;
        both_fire = 0;
        pf        = pnode_valid && pnode_ready;
        if (pf) begin
            if (sent_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL pnode_spurious: got record %0h, required no record pending", pnode_data);
            end else begin
                chk("pnode_data", pnode_data, sent_q[0]);
                iss_q.push_back(sent_q.pop_front());
                if (freeze_req || dead) begin
                    fate_q.push_back(2);
                end else begin
                    fate_q.push_back(0);
                    reg_k.push_back(n_issued);
                    lat = $urandom_range(lat_max, lat_min);
                    reg_t.push_back(cyc + lat);
                end
                n_issued++;
            end
        end
        if (result_ack) begin
            if (from_region) begin
                fate_q[reg_k[0]] = 1;
                void'(reg_k.pop_front());
                void'(reg_t.pop_front());
                n_ret++;
                acks_seen++;
                if (pf) both_fire = 1;
            end else begin
                n_cmp++; n_bad++;
                $display("FAIL ack_no_live_result: got result_ack=1 with valid=%0b stale=%0b, required 0",
                         result_valid, stale);
            end
        end
        if (in_valid && in_ready) begin
            sent_q.push_back(feed_q.pop_front());
            in_present = 0;
        end
        if (out_valid && out_ready) begin
            if (n_out >= fate_q.size() || fate_q[n_out] == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL out_unresolved: got out_result=%0h for request %0d, required no output yet",
                         out_result, n_out);
            end else begin
                exp = (fate_q[n_out] == 1) ? f_res(iss_q[n_out]) : MISS;
                chk("out_result", out_result, exp);
                if (fate_q[n_out] == 2) n_miss++;
            end
            out_log.push_back(out_result);
            n_out++;
        end
        chk("inflight_bound", ((n_issued - n_out) <= MAXO + 1), 1);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        rd_en = 1; rd_addr = a;
        step();
        rd_en = 0;
        step();
        v = last_rd;
    endtask

    task automatic wait_out(input int n, input int bound, input string name);
        int c = 0;
        while (n_out < n && c < bound) begin step(); c++; end
        chk(name, n_out, n);
    endtask

    task automatic wait_issued(input int n, input int bound, input string name);
        int c = 0;
        while (n_issued < n && c < bound) begin step(); c++; end
        chk(name, n_issued, n);
    endtask

    task automatic feed(input int s);
        feed_q.push_back(mk_rec(s));
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        in_valid = 0; result_valid = 0; coe_freeze = 0; avs_status_read = 0;
        feed_q.delete(); sent_q.delete(); iss_q.delete(); fate_q.delete();
        reg_k.delete(); reg_t.delete(); out_log.delete();
        n_issued = 0; n_ret = 0; n_miss = 0; n_out = 0; acks_seen = 0; in_present = 0;
        iv_rate = 100; pr_rate = 100; or_rate = 100; lat_min = 1; lat_max = 1;
        freeze_req = 0; dead = 0; hold = 0; stale = 0; rd_en = 0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] v;
        int fz_cnt;
        int c;
        cyc = 0;

        // Reset state, with a record offered during reset.
        reset = 1'b1;
        in_valid = 1'b1;
        in_data = mk_rec(5);
        repeat (3) @(negedge clock);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_pnode_valid", pnode_valid, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result_ack", result_ack, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_readdata", avs_status_readdata, 0);
        do_reset();
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v);
            chk("rst_status", v, 0);
        end

        // Echo stream: results 0..7 in order with fixed region latency.
        do_reset();
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 8; i++) feed(i);
        wait_out(8, 300, "echo_done");
        for (int i = 0; i < 8 && i < out_log.size(); i++) chk("echo_literal", out_log[i], 14'(i));
        rd(2'd0, v); chk("echo_issued", v, 8);
        rd(2'd1, v); chk("echo_returned", v, 8);
        rd(2'd2, v); chk("echo_miss", v, 0);

        // Silent region: credit limit, then timeout drain to misses.
        do_reset();
        dead = 1;
        for (int i = 0; i < 5; i++) feed(20 + i);
        repeat (30) step();
        chk("credit_issued", n_issued, MAXO);
        chk("credit_pnode_valid", pnode_valid, 0);
        wait_out(4, 300, "timeout_drain");
        for (int i = 0; i < 4 && i < out_log.size(); i++) chk("timeout_miss_literal", out_log[i], MISS);
        rd(2'd2, v); chk("timeout_miss_cnt", v, 4);
        rd(2'd3, v); chk("timeout_state_run", v[1:0], 0);

        // Freeze with two outstanding, stale results while frozen, then resume.
        do_reset();
        lat_min = 200; lat_max = 200;
        feed(40); feed(41);
        wait_issued(2, 50, "freeze_issue2");
        freeze_req = 1;
        feed(42);
        wait_out(2, 100, "freeze_drain");
        for (int i = 0; i < 2 && i < out_log.size(); i++) chk("freeze_miss_literal", out_log[i], MISS);
        rd(2'd3, v); chk("freeze_status", v, 32'h2);
        stale = 1;
        feed(43);
        repeat (10) step();
        chk("frozen_in_ready", in_ready, 0);
        chk("frozen_pnode_valid", pnode_valid, 0);
        chk("frozen_no_ack", n_ret, 0);
        stale = 0; lat_min = 2; lat_max = 2;
        freeze_req = 0;
        step();
        step();
        chk("unfreeze_issue", pnode_valid, 1);
        wait_out(4, 100, "unfreeze_done");
        if (out_log.size() >= 3) chk("unfreeze_literal", out_log[2], 14'd42);

        // Downstream stall: one result held, no further acks, nothing lost.
        do_reset();
        or_rate = 0;
        feed(100); feed(101); feed(102);
        repeat (20) begin
            step();
            if (out_valid) chk("stall_hold", out_result, 14'd100);
        end
        chk("stall_acks", acks_seen, 1);
        chk("stall_out_valid", out_valid, 1);
        chk("stall_ack_low", result_ack, 0);
        or_rate = 100;
        wait_out(3, 100, "stall_done");

        // Same-cycle issue and result at two outstanding.
        do_reset();
        hold = 1;
        feed(60); feed(61);
        wait_issued(2, 50, "same_issue2");
        pr_rate = 0;
        feed(62);
        repeat (4) step();
        hold = 0; pr_rate = 100;
        step();
        chk("same_both_fire", both_fire, 1);
        hold = 1; pr_rate = 0;
        rd(2'd3, v); chk("same_outstanding", v, 32'h20);
        hold = 0; pr_rate = 100;
        wait_out(3, 100, "same_done");

        // Randomized traffic with occasional freeze episodes.
        do_reset();
        iv_rate = 70; pr_rate = 70; or_rate = 75; lat_min = 1; lat_max = 6;
        serial = 0;
        fz_cnt = 0;
        c = 0;
        while (c < 3000 || freeze_req) begin
            if (c < 3000 && feed_q.size() < 3) begin feed(serial); serial++; end
            if (!freeze_req && c < 2900 && $urandom_range(149) == 0) begin
                freeze_req = 1; fz_cnt = 0;
            end else if (freeze_req) begin
                fz_cnt++;
                if (fz_cnt >= 6 && n_out == n_issued) freeze_req = 0;
                if (fz_cnt > 400) begin
                    n_cmp++; n_bad++;
                    $display("FAIL freeze_drain_bound: got %0d outputs, required %0d", n_out, n_issued);
                    freeze_req = 0;
                end
            end
            step();
            c++;
        end
        c = 0;
        while ((feed_q.size() > 0 || sent_q.size() > 0 || n_out < n_issued) && c < 500) begin
            step(); c++;
        end
        chk("rand_settled", n_out, n_issued);
        rd(2'd0, v); chk("rand_issued", v, n_issued);
        rd(2'd1, v); chk("rand_returned", v, n_ret);
        rd(2'd2, v); chk("rand_miss", v, n_miss);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
